deserializador_fifo: RTL and testbench

Parametrised serial-to-parallel converter with an output word FIFO. It assembles `WIDTH`-bit words from a bit stream qualified by `write_in`, in a selectable bit order. Completed words are queued in a `DEPTH`-entry buffer and popped with `ack_in`, so the serial side keeps running while the consumer is slow. It is the next-generation deserializer in the serial link path: it adds back-pressure, framing-error reporting and overflow reporting.

---
 rtl/deserializador_pkg.sv | 14 +
 rtl/deserializador_fifo_sync_fifo.sv | 61 ++++++
 rtl/deserializador_fifo.sv | 118 +++++++++++
 tb/tb_deserializador_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/deserializador_pkg.sv
// Shared types and sizing helpers for the serial-to-parallel converter.
package deserializador_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RECEIVE = 1'b1
   } state_t;

   // Bit-counter width; WIDTH is at least 2, so the counter needs at least one bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/deserializador_fifo_sync_fifo.sv
// Word FIFO with count-derived full/empty; a pop on the same edge makes room for a push even when full.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CNTW = PW + 1;
   localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/deserializador_fifo.sv
// Serial-to-parallel converter feeding a word FIFO, with framing-error and overflow pulses.
//  state   | meaning
//  IDLE    | no bits of the current word held
//  RECEIVE | 1..WIDTH-1 bits held in the shift register
module deserializador_fifo
   import deserializador_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 0
) (
   input  logic                   clock_100KHz,
   input  logic                   reset,
   input  logic                   write_in,
   input  logic                   data_in,
   input  logic                   ack_in,
   output logic                   data_ready,
   output logic [WIDTH-1:0]       data_out,
   output logic                   status_out,
   output logic                   frame_error,
   output logic                   overflow,
   output logic [$clog2(DEPTH):0] word_count
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    pos;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] word;
   logic             push;
   logic             frame_error_q, frame_error_d;
   logic             overflow_q, overflow_d;
   logic             fifo_full, fifo_empty;

   // Bits are stored at their final position, so the completed word needs no reordering.
   assign pos = (MSB_FIRST != 0) ? (CW'(WIDTH - 1) - cnt_q) : cnt_q;

   always_comb begin
      word      = shreg_q;
      word[pos] = data_in;
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      shreg_d       = shreg_q;
      push          = 1'b0;
      frame_error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (write_in) begin
               shreg_d = word;
               cnt_d   = CW'(1);
               state_d = RECEIVE;
            end
         end
         RECEIVE: begin
            if (!write_in) begin
               shreg_d       = '0;
               cnt_d         = '0;
               frame_error_d = 1'b1;
               state_d       = IDLE;
            end else if (cnt_q == CW'(WIDTH - 1)) begin
               push    = 1'b1;
               shreg_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               shreg_d = word;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A pop on the same edge frees the head slot, so the push is then never dropped.
   assign overflow_d = push && fifo_full && !(ack_in && !fifo_empty);

   always_ff @(posedge clock_100KHz or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         shreg_q       <= '0;
         frame_error_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         shreg_q       <= shreg_d;
         frame_error_q <= frame_error_d;
         overflow_q    <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clock_100KHz),
      .rst_ni  (reset),
      .push_i  (push),
      .pop_i   (ack_in),
      .wdata_i (word),
      .rdata_o (data_out),
      .count_o (word_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign data_ready  = !fifo_empty;
   assign status_out  = fifo_full;
   assign frame_error = frame_error_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_deserializador_fifo.sv
// Directed bench: an LSB-first and an MSB-first instance share one serial stream.
module tb_deserializador_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       write_in = 1'b0;
   logic       data_in = 1'b0;
   logic       ack_in = 1'b0;

   logic       dl_ready, dl_status, dl_fe, dl_ov;
   logic [7:0] dl_data;
   logic [2:0] dl_count;
   logic       dm_ready, dm_status, dm_fe, dm_ov;
   logic [7:0] dm_data;
   logic [2:0] dm_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) dut_l (
      .clock_100KHz (clk),
      .reset        (rst_n),
      .write_in     (write_in),
      .data_in      (data_in),
      .ack_in       (ack_in),
      .data_ready   (dl_ready),
      .data_out     (dl_data),
      .status_out   (dl_status),
      .frame_error  (dl_fe),
      .overflow     (dl_ov),
      .word_count   (dl_count)
   );

   deserializador_fifo #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) dut_m (
      .clock_100KHz (clk),
      .reset        (rst_n),
      .write_in     (write_in),
      .data_in      (data_in),
      .ack_in       (ack_in),
      .data_ready   (dm_ready),
      .data_out     (dm_data),
      .status_out   (dm_status),
      .frame_error  (dm_fe),
      .overflow     (dm_ov),
      .word_count   (dm_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      write_in = 1'b1;
      data_in  = b;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) send_bit(w[i]);
   endtask

   task automatic pop_word();
      ack_in = 1'b1;
      @(negedge clk);
      ack_in = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_l_ready"},  32'(dl_ready),  0);
      chk({tag, "_l_data"},   32'(dl_data),   0);
      chk({tag, "_l_status"}, 32'(dl_status), 0);
      chk({tag, "_l_fe"},     32'(dl_fe),     0);
      chk({tag, "_l_ov"},     32'(dl_ov),     0);
      chk({tag, "_l_count"},  32'(dl_count),  0);
      chk({tag, "_m_ready"},  32'(dm_ready),  0);
      chk({tag, "_m_data"},   32'(dm_data),   0);
      chk({tag, "_m_count"},  32'(dm_count),  0);
   endtask

   initial begin
      logic [7:0] a5 = 8'hA5;

      // Reset state
      #2;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // A5, LSB-first stream; palindrome so both orders give A5
      for (int i = 0; i < 7; i++) send_bit(a5[i]);
      chk("a5_not_ready_early", 32'(dl_ready), 0);
      send_bit(a5[7]);
      write_in = 1'b0;
      chk("a5_ready",   32'(dl_ready), 1);
      chk("a5_l_data",  32'(dl_data),  32'hA5);
      chk("a5_m_data",  32'(dm_data),  32'hA5);
      chk("a5_count",   32'(dl_count), 1);
      pop_word();
      chk("a5_pop_ready_l", 32'(dl_ready), 0);
      chk("a5_pop_ready_m", 32'(dm_ready), 0);
      chk("a5_pop_count",   32'(dl_count), 0);
      chk("a5_no_fe",       32'(dl_fe),    0);

      // Bits 1,1,0,0,0,0,0,0: LSB-first 03, MSB-first C0
      send_word(8'h03);
      write_in = 1'b0;
      chk("order_l", 32'(dl_data), 32'h03);
      chk("order_m", 32'(dm_data), 32'hC0);
      pop_word();

      // Abort after 5 bits
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      write_in = 1'b0;
      @(negedge clk);
      chk("abort_fe_l",    32'(dl_fe),    1);
      chk("abort_fe_m",    32'(dm_fe),    1);
      chk("abort_no_push", 32'(dl_ready), 0);
      @(negedge clk);
      chk("abort_fe_pulse", 32'(dl_fe), 0);
      send_word(8'h3C);
      write_in = 1'b0;
      chk("after_abort_l",     32'(dl_data),  32'h3C);
      chk("after_abort_m",     32'(dm_data),  32'h3C);
      chk("after_abort_count", 32'(dl_count), 1);
      pop_word();

      // Fill and overflow, back-to-back words
      for (int w = 1; w <= 3; w++) send_word(8'(w));
      chk("fill3_status", 32'(dl_status), 0);
      chk("fill3_count",  32'(dl_count),  3);
      send_word(8'h04);
      chk("fill4_status_l", 32'(dl_status), 1);
      chk("fill4_status_m", 32'(dm_status), 1);
      chk("fill4_count",    32'(dl_count),  4);
      send_word(8'h05);
      write_in = 1'b0;
      chk("ovf_pulse_l", 32'(dl_ov), 1);
      chk("ovf_pulse_m", 32'(dm_ov), 1);
      @(negedge clk);
      chk("ovf_pulse_end", 32'(dl_ov),    0);
      chk("ovf_count",     32'(dl_count), 4);
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ovf_pop%0d", k), 32'(dl_data), 32'(k));
         pop_word();
      end
      chk("ovf_drained", 32'(dl_ready), 0);

      // Full FIFO: last bit and ack on the same edge
      send_word(8'h11);
      send_word(8'h22);
      send_word(8'h33);
      send_word(8'h44);
      for (int i = 0; i < 7; i++) send_bit(1'(8'h55 >> i));
      write_in = 1'b1;
      data_in  = 1'b0;
      ack_in   = 1'b1;
      @(negedge clk);
      write_in = 1'b0;
      ack_in   = 1'b0;
      chk("simul_no_ovf", 32'(dl_ov),     0);
      chk("simul_count",  32'(dl_count),  4);
      chk("simul_status", 32'(dl_status), 1);
      chk("simul_head",   32'(dl_data),   32'h22);
      pop_word();
      chk("simul_pop33", 32'(dl_data), 32'h33);
      pop_word();
      chk("simul_pop44", 32'(dl_data), 32'h44);
      pop_word();
      chk("simul_tail55", 32'(dl_data), 32'h55);
      pop_word();
      chk("simul_empty", 32'(dl_ready), 0);

      // Async reset mid-word with two words queued
      send_word(8'hAA);
      send_word(8'hBB);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      chk("pre_reset_count", 32'(dl_count), 2);
      #2;
      rst_n    = 1'b0;
      write_in = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_fe",    32'(dl_fe),    0);
      chk("post_rst_ready", 32'(dl_ready), 0);
      send_word(8'hFF);
      write_in = 1'b0;
      chk("post_rst_l",     32'(dl_data),  32'hFF);
      chk("post_rst_m",     32'(dm_data),  32'hFF);
      chk("post_rst_count", 32'(dl_count), 1);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
